// File: rtl/alu_issue_stage_pkg.sv
// Shared types for the ALU issue stage.
// Flag indices, FSM states and the instruction bundle.
package alu_pkg;

  localparam int ALU_BW  = 16;
  localparam int NREG_DEF = 8;
  localparam int AW_DEF  = $clog2(NREG_DEF);

  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_ZERO = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic [3:0]        op;
    logic [AW_DEF-1:0] dst;
    logic [AW_DEF-1:0] src_a;
    logic [AW_DEF-1:0] src_b;
    logic              imm_sel;
    logic [ALU_BW-1:0] imm;
  } instr_t;

endpackage

// File: rtl/alu_issue_stage_if.sv
// Instruction valid/ready channel into the issue stage.
// master = instruction source, slave = issue stage.
interface alu_issue_if #(
  parameter int BW = 16,
  parameter int AW = 3
);
  logic          instr_valid;
  logic          instr_ready;
  logic [3:0]    instr_op;
  logic [AW-1:0] instr_dst;
  logic [AW-1:0] instr_src_a;
  logic [AW-1:0] instr_src_b;
  logic          instr_imm_sel;
  logic [BW-1:0] instr_imm;

  modport master (
    output instr_valid,
    output instr_op,
    output instr_dst,
    output instr_src_a,
    output instr_src_b,
    output instr_imm_sel,
    output instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr_op,
    input  instr_dst,
    input  instr_src_a,
    input  instr_src_b,
    input  instr_imm_sel,
    input  instr_imm,
    output instr_ready
  );

endinterface

// File: rtl/alu_issue_stage_regfile.sv
// NREG x BW register file: 2 async reads, 1 sync write.
// Option ALU_ISSUE_REG0_ZERO_EN hardwires reg 0 to zero.
module alu_regfile #(
  parameter int BW   = 16,
  parameter int NREG = 8,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] ra_addr,
  output logic [BW-1:0] ra_data,
  input  logic [AW-1:0] rb_addr,
  output logic [BW-1:0] rb_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [BW-1:0] wd
);

  logic [BW-1:0] mem [NREG];
  logic          wr_ok;

`ifdef ALU_ISSUE_REG0_ZERO_EN
  assign wr_ok   = (wa != '0);
  assign ra_data = (ra_addr == '0) ? '0 : mem[ra_addr];
  assign rb_data = (rb_addr == '0) ? '0 : mem[rb_addr];
`else
  assign wr_ok   = 1'b1;
  assign ra_data = mem[ra_addr];
  assign rb_data = mem[rb_addr];
`endif

  // clear on reset, single write port otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++)
        mem[i] <= '0;
    end else if (we && wr_ok) begin
      mem[wa] <= wd;
    end
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback stage around a combinational ALU.
// Optional: ALU_ISSUE_REG0_ZERO_EN (reg 0 reads as zero).
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int BW   = ALU_BW,
  parameter int NREG = NREG_DEF,
  localparam int AW  = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  alu_issue_if.slave    instr,
  output logic [BW-1:0] alu_in_a,
  output logic [BW-1:0] alu_in_b,
  output logic [3:0]    alu_opcode,
  input  logic [BW-1:0] alu_out,
  input  logic [2:0]    alu_flags,
  output logic          wb_valid,
  output logic [AW-1:0] wb_dst,
  output logic [BW-1:0] wb_data,
  output logic [2:0]    flags_q
);

  state_t        state_q;
  state_t        state_d;
  logic          ready;
  logic          accept;
  logic [AW-1:0] dst_q;
  logic [BW-1:0] rd_a;
  logic [BW-1:0] rd_b;
  logic [BW-1:0] opnd_b;

  assign instr.instr_ready = ready;
  assign accept = instr.instr_valid & ready;
  assign opnd_b = instr.instr_imm_sel ? instr.instr_imm : rd_b;

  alu_regfile #(
    .BW   (BW),
    .NREG (NREG)
  ) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (instr.instr_src_a),
    .ra_data (rd_a),
    .rb_addr (instr.instr_src_b),
    .rb_data (rd_b),
    .we      (wb_valid),
    .wa      (wb_dst),
    .wd      (wb_data)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state: one instruction in flight
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    ready    = 1'b0;
    wb_valid = 1'b0;
    unique case (state_q)
      IDLE:    ready    = 1'b1;
      WB:      wb_valid = 1'b1;
      default: ;
    endcase
  end

  // operand latch on accept, result capture at end of EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_in_a   <= '0;
      alu_in_b   <= '0;
      alu_opcode <= '0;
      dst_q      <= '0;
      wb_data    <= '0;
      wb_dst     <= '0;
      flags_q    <= '0;
    end else begin
      if (accept) begin
        alu_in_a   <= rd_a;
        alu_in_b   <= opnd_b;
        alu_opcode <= instr.instr_op;
        dst_q      <= instr.instr_dst;
      end
      if (state_q == EXEC) begin
        wb_data <= alu_out;
        wb_dst  <= dst_q;
        flags_q <= alu_flags;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a small ALU model.
// Honours ALU_ISSUE_REG0_ZERO_EN for the reg 0 check.
module tb_alu_issue_stage;
  import alu_pkg::*;

  localparam logic [3:0] OPADD  = 4'd0;
  localparam logic [3:0] OPPASS = 4'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] alu_in_a;
  logic [15:0] alu_in_b;
  logic [3:0]  alu_opcode;
  logic [15:0] alu_out;
  logic [2:0]  alu_flags;
  logic        wb_valid;
  logic [2:0]  wb_dst;
  logic [15:0] wb_data;
  logic [2:0]  flags_q;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_if #(.BW(16), .AW(3)) bus ();

  alu_issue_stage #(.BW(16), .NREG(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .instr      (bus),
    .alu_in_a   (alu_in_a),
    .alu_in_b   (alu_in_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags),
    .wb_valid   (wb_valid),
    .wb_dst     (wb_dst),
    .wb_data    (wb_data),
    .flags_q    (flags_q)
  );

  always #5 clk = ~clk;

  always_comb begin
    alu_out   = '0;
    alu_flags = '0;
    case (alu_opcode)
      OPADD: begin
        alu_out = alu_in_a + alu_in_b;
        alu_flags[FLAG_OVF] = (alu_in_a[15] == alu_in_b[15]) &&
                              (alu_out[15] != alu_in_a[15]);
      end
      OPPASS: alu_out = alu_in_a;
      default: alu_out = '0;
    endcase
    alu_flags[FLAG_NEG]  = alu_out[15];
    alu_flags[FLAG_ZERO] = (alu_out == '0);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input instr_t i);
    bus.instr_op      = i.op;
    bus.instr_dst     = i.dst;
    bus.instr_src_a   = i.src_a;
    bus.instr_src_b   = i.src_b;
    bus.instr_imm_sel = i.imm_sel;
    bus.instr_imm     = i.imm;
  endtask

  task automatic issue(input string tag, input instr_t i,
                       input logic [15:0] ea, input logic [15:0] eb,
                       input logic [15:0] ed, input logic [2:0] ef,
                       input bit hold);
    chk({tag, "_rdy0"}, 32'(bus.instr_ready), 32'd1);
    drive(i);
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    if (!hold) bus.instr_valid = 1'b0;
    chk({tag, "_ina"}, 32'(alu_in_a), 32'(ea));
    chk({tag, "_inb"}, 32'(alu_in_b), 32'(eb));
    chk({tag, "_opc"}, 32'(alu_opcode), 32'(i.op));
    chk({tag, "_wbv0"}, 32'(wb_valid), 32'd0);
    chk({tag, "_rdyx"}, 32'(bus.instr_ready), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_wbv1"}, 32'(wb_valid), 32'd1);
    chk({tag, "_dst"}, 32'(wb_dst), 32'(i.dst));
    chk({tag, "_data"}, 32'(wb_data), 32'(ed));
    chk({tag, "_flg"}, 32'(flags_q), 32'(ef));
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    chk({tag, "_wbv2"}, 32'(wb_valid), 32'd0);
    chk({tag, "_rdy2"}, 32'(bus.instr_ready), 32'd1);
    chk({tag, "_hold"}, 32'(wb_data), 32'(ed));
    chk({tag, "_ina_h"}, 32'(alu_in_a), 32'(ea));
  endtask

  function automatic instr_t mk(input logic [3:0] op,
                                input logic [2:0] dst,
                                input logic [2:0] sa,
                                input logic [2:0] sb,
                                input logic sel,
                                input logic [15:0] imm);
    instr_t r;
    r.op = op; r.dst = dst; r.src_a = sa;
    r.src_b = sb; r.imm_sel = sel; r.imm = imm;
    return r;
  endfunction

  logic [15:0] r0_exp;

  initial begin
    bus.instr_valid = 1'b0;
    drive(mk(4'd0, 3'd0, 3'd0, 3'd0, 1'b0, 16'd0));
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1: idle state after reset
    chk("rst_rdy", 32'(bus.instr_ready), 32'd1);
    chk("rst_ina", 32'(alu_in_a), 32'd0);
    chk("rst_inb", 32'(alu_in_b), 32'd0);
    chk("rst_opc", 32'(alu_opcode), 32'd0);
    chk("rst_wbv", 32'(wb_valid), 32'd0);
    chk("rst_dst", 32'(wb_dst), 32'd0);
    chk("rst_dat", 32'(wb_data), 32'd0);
    chk("rst_flg", 32'(flags_q), 32'd0);
    issue("t1", mk(OPPASS, 3'd5, 3'd3, 3'd0, 1'b1, 16'd0),
          16'h0, 16'h0, 16'h0, 3'b001, 1'b0);

    // 2: immediate add
    issue("t2", mk(OPADD, 3'd2, 3'd1, 3'd0, 1'b1, 16'h0005),
          16'h0, 16'h5, 16'h0005, 3'b000, 1'b0);

    // 3: dependent op right after WB, valid held
    issue("t3", mk(OPADD, 3'd2, 3'd2, 3'd2, 1'b0, 16'hFFFF),
          16'h5, 16'h5, 16'h000A, 3'b000, 1'b1);

    // 4: signed overflow
    issue("t4a", mk(OPADD, 3'd1, 3'd0, 3'd0, 1'b1, 16'h7FFF),
          16'h0, 16'h7FFF, 16'h7FFF, 3'b000, 1'b0);
    issue("t4b", mk(OPADD, 3'd3, 3'd1, 3'd0, 1'b1, 16'h0001),
          16'h7FFF, 16'h1, 16'h8000, 3'b110, 1'b0);

    // 5: reset during EXEC
    drive(mk(OPADD, 3'd4, 3'd1, 3'd0, 1'b1, 16'h0001));
    bus.instr_valid = 1'b1;
    @(posedge clk); #1;
    bus.instr_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_wbv", 32'(wb_valid), 32'd0);
    chk("t5_ina", 32'(alu_in_a), 32'd0);
    chk("t5_flg", 32'(flags_q), 32'd0);
    rst = 1'b0;
    chk("t5_rdy", 32'(bus.instr_ready), 32'd1);
    @(posedge clk); #1;
    chk("t5_wbv2", 32'(wb_valid), 32'd0);
    chk("t5_rdy2", 32'(bus.instr_ready), 32'd1);
    issue("t5r", mk(OPPASS, 3'd6, 3'd4, 3'd0, 1'b1, 16'h0),
          16'h0, 16'h0, 16'h0, 3'b001, 1'b0);

    // 6: register 0 behaviour
`ifdef ALU_ISSUE_REG0_ZERO_EN
    r0_exp = 16'h0000;
`else
    r0_exp = 16'h1234;
`endif
    issue("t6w", mk(OPADD, 3'd0, 3'd0, 3'd0, 1'b1, 16'h1234),
          16'h0, 16'h1234, 16'h1234, 3'b000, 1'b0);
    issue("t6r", mk(OPPASS, 3'd7, 3'd0, 3'd0, 1'b1, 16'h0),
          r0_exp, 16'h0, r0_exp, {1'b0, r0_exp[15], r0_exp == 16'h0},
          1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream operand/issue stage for the combinational `alu`.
- Holds an NREG x BW register file and accepts one instruction per valid/ready handshake.
- Drives registered operands and opcode into the ALU, captures `out`/`flags`, then writes the result back.
- Forms the minimal datapath controller around the ALU; one instruction in flight at a time.

Parameters:
- BW, 16, datapath width; must match the ALU's BW.
- NREG, 8, number of registers (power of 2, >= 2).
- AW, $clog2(NREG), register address width; derived, not overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- instr_valid  in  1  instruction offered.
- instr_ready  out  1  stage can accept; high only in IDLE.
- instr_op  in  4  ALU opcode, passed through unchanged.
- instr_dst  in  AW  destination register.
- instr_src_a  in  AW  operand A register.
- instr_src_b  in  AW  operand B register.
- instr_imm_sel  in  1  1: operand B = instr_imm; 0: operand B = reg[src_b].
- instr_imm  in  BW  immediate operand.
- alu_in_a  out  BW  to ALU in_a, registered.
- alu_in_b  out  BW  to ALU in_b, registered.
- alu_opcode  out  4  to ALU opcode, registered.
- alu_out  in  BW  from ALU out (combinational from alu_in_*).
- alu_flags  in  3  from ALU flags {overflow, negative, zero}.
- wb_valid  out  1  one-cycle pulse: result written.
- wb_dst  out  AW  register written.
- wb_data  out  BW  value written.
- flags_q  out  3  flags of the last completed instruction.

Behaviour:
- FSM states: IDLE, EXEC, WB.
- IDLE: instr_ready=1. On instr_valid & instr_ready at a clock edge:
  - alu_in_a <= reg[src_a].
  - alu_in_b <= imm_sel ? imm : reg[src_b].
  - alu_opcode <= op; dst latched internally.
  - state -> EXEC.
  - instr_valid without ready is ignored; no instruction is queued.
- EXEC: exactly one cycle; the ALU settles. At the edge:
  - res_q <= alu_out; flags_q <= alu_flags.
  - state -> WB.
- WB: exactly one cycle.
  - wb_valid=1, wb_dst=dst, wb_data=res_q.
  - reg[dst] <= res_q at the edge; state -> IDLE.
- Latency: accept edge -> wb_valid high 2 cycles later. Throughput: 1 instruction per 3 cycles.
- alu_in_a, alu_in_b and alu_opcode hold their values outside EXEC; they change only on accept.
- Hazards: an instruction accepted right after WB reads the already-written value. No bypass needed.
- src_a == src_b == dst is legal; reads use the old value and the write lands in WB.
- Register file: two combinational read ports, one synchronous write port. Write only in WB.
- wb_data and wb_dst hold their last values when wb_valid=0.
- Reset at any point, including mid-EXEC/WB:
  - state=IDLE; the in-flight instruction is dropped with no writeback.
  - All registers = 0; alu_in_a = alu_in_b = 0; alu_opcode = 0.
  - res_q = 0; flags_q = 0; wb_valid = 0; wb_dst = 0; wb_data = 0.
  - instr_ready = 1 in the first cycle after reset deasserts.
- No arithmetic is done here; widths pass through unchanged; flags are not interpreted.

Optional Feature:
- Macro ALU_ISSUE_REG0_ZERO_EN.
- Defined: register 0 is hardwired to zero.
  - Reads of reg 0 return 0.
  - Writes to reg 0 are discarded, but wb_valid still pulses with wb_dst=0 and wb_data=res_q.
  - flags_q still updates.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package alu_pkg:
  - BW default.
  - Flag bit indices: FLAG_OVF=2, FLAG_NEG=1, FLAG_ZERO=0.
  - State enum {IDLE, EXEC, WB}.
  - Packed instruction struct {op, dst, src_a, src_b, imm_sel, imm}.
- Sub-module alu_regfile: NREG x BW, 2 async reads, 1 sync write, sync reset clear. Carries the REG0_ZERO option.

Test Plan:
- Bench connects the real alu; OPADD denotes its add opcode.
1. Reset, then check idle outputs: all outputs 0, instr_ready=1; reading reg 3 via a pass-through op gives 0.
2. Immediate add: reg1=0, OPADD src_a=1, imm_sel=1, imm=0x0005, dst=2 -> wb_valid exactly 2 cycles after accept, wb_data=0x0005, wb_dst=2, flags_q=3'b000.
3. Back-to-back dependence: after test 2, OPADD src_a=2, src_b=2, dst=2 offered the cycle after WB -> wb_data=0x000A. instr_valid held high during EXEC/WB causes no extra accepts.
4. Overflow: reg1=0x7FFF, OPADD with imm=0x0001 -> wb_data=0x8000, flags_q=3'b110.
5. Reset during EXEC: assert rst one cycle after accept -> no wb_valid pulse, destination register stays 0, instr_ready=1 the next cycle.
6. Register 0: with ALU_ISSUE_REG0_ZERO_EN, write 0x1234 to dst=0, then read reg 0 -> 0. Without the macro the read returns 0x1234.
